regfile_2r1w_sb: RTL

//  Parametrised register file: two registered read ports, one write port, and a per-entry busy

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_read_port.sv | 73 +++++++
 rtl/regfile_2r1w_sb.sv | 90 +++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults, types and address helpers for the 2-read/1-write register file.
package regfile_pkg;

  localparam int unsigned RF_DATA_W   = 16;
  localparam int unsigned RF_NUM_REGS = 8;

  typedef logic [$clog2(RF_NUM_REGS)-1:0] rf_addr_t;
  typedef logic [RF_DATA_W-1:0]           rf_data_t;

  // True when addr names a real entry; only matters for non-power-of-two sizes.
  function automatic logic rf_in_range(input int unsigned addr, input int unsigned num_regs);
    return addr < num_regs;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: effective busy/data selection plus output registers.
// Build option REGFILE_BYPASS_EN forwards a same-cycle write to the read.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = RF_DATA_W,
  parameter int unsigned NUM_REGS = RF_NUM_REGS,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
  parameter int unsigned ZERO_R0  = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             rd_en,
  input  logic [ADDR_W-1:0]                rd_addr,
  input  logic [NUM_REGS-1:0][DATA_W-1:0]  regs,
  input  logic [NUM_REGS-1:0]              busy,
  input  logic                             wr_en,
  input  logic [ADDR_W-1:0]                wr_addr,
  input  logic [DATA_W-1:0]                wr_data,
  output logic [DATA_W-1:0]                rd_data,
  output logic                             rd_valid
);

  logic              in_range;
  logic              is_zero;
  logic [DATA_W-1:0] data_eff;
  logic              busy_eff;
  logic [DATA_W-1:0] rd_data_p1;
  logic              vld_p1;

  assign in_range = rf_in_range(32'(rd_addr), NUM_REGS);
  assign is_zero  = (ZERO_R0 != 0) && (rd_addr == '0);

  // Out-of-range reads look permanently busy so they never validate.
  always_comb begin
    data_eff = '0;
    busy_eff = 1'b1;
    if (in_range) begin
      data_eff = regs[rd_addr];
      busy_eff = busy[rd_addr];
    end
`ifdef REGFILE_BYPASS_EN
    if (in_range && wr_en && (wr_addr == rd_addr)) begin
      data_eff = wr_data;
      busy_eff = 1'b0;
    end
`endif
    if (is_zero) begin
      data_eff = '0;
      busy_eff = 1'b0;
    end
  end

`ifndef REGFILE_BYPASS_EN
  logic unused_wr;
  assign unused_wr = ^{wr_en, wr_addr, wr_data};
`endif

  // Stage p1: registered read result
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_p1 <= '0;
      vld_p1     <= 1'b0;
    end else begin
      vld_p1 <= rd_en & ~busy_eff;
      if (rd_en) rd_data_p1 <= data_eff;
    end
  end

  assign rd_data  = rd_data_p1;
  assign rd_valid = vld_p1;

endmodule

// File: rtl/regfile_2r1w_sb.sv
// Register file with two registered read ports, one write port and a busy scoreboard.
// Build option REGFILE_BYPASS_EN enables write-to-read forwarding in the read ports.
module regfile_2r1w_sb
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = RF_DATA_W,
  parameter int unsigned NUM_REGS = RF_NUM_REGS,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
  parameter int unsigned ZERO_R0  = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                lock_en,
  input  logic [ADDR_W-1:0]   lock_addr,
  input  logic                rd0_en,
  input  logic [ADDR_W-1:0]   rd0_addr,
  output logic [DATA_W-1:0]   rd0_data,
  output logic                rd0_valid,
  input  logic                rd1_en,
  input  logic [ADDR_W-1:0]   rd1_addr,
  output logic [DATA_W-1:0]   rd1_data,
  output logic                rd1_valid,
  output logic [NUM_REGS-1:0] busy
);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;
  logic [NUM_REGS-1:0]             busy_q;
  logic                            wr_ok;
  logic                            lock_ok;

  logic [1:0]             rd_en_v;
  logic [1:0][ADDR_W-1:0] rd_addr_v;
  logic [1:0][DATA_W-1:0] rd_data_v;
  logic [1:0]             rd_valid_v;

  // With ZERO_R0, entry 0 is hard-wired: writes and locks to it are dropped.
  assign wr_ok   = wr_en && rf_in_range(32'(wr_addr), NUM_REGS) &&
                   !((ZERO_R0 != 0) && (wr_addr == '0));
  assign lock_ok = lock_en && rf_in_range(32'(lock_addr), NUM_REGS) &&
                   !((ZERO_R0 != 0) && (lock_addr == '0));

  // Lock is applied after the write so a same-address lock keeps the entry busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= '0;
      busy_q <= '0;
    end else begin
      if (wr_ok) begin
        regs_q[wr_addr] <= wr_data;
        busy_q[wr_addr] <= 1'b0;
      end
      if (lock_ok) busy_q[lock_addr] <= 1'b1;
    end
  end

  assign busy = busy_q;

  assign rd_en_v   = {rd1_en, rd0_en};
  assign rd_addr_v = {rd1_addr, rd0_addr};

  for (genvar p = 0; p < 2; p++) begin : g_rd
    regfile_read_port #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W),
      .ZERO_R0  (ZERO_R0)
    ) u_port (
      .clk      (clk),
      .reset    (reset),
      .rd_en    (rd_en_v[p]),
      .rd_addr  (rd_addr_v[p]),
      .regs     (regs_q),
      .busy     (busy_q),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_data  (rd_data_v[p]),
      .rd_valid (rd_valid_v[p])
    );
  end

  assign rd0_data  = rd_data_v[0];
  assign rd0_valid = rd_valid_v[0];
  assign rd1_data  = rd_data_v[1];
  assign rd1_valid = rd_valid_v[1];

endmodule
